// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the byte-serial instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADR_LO,
    ST_ADR_HI,
    ST_COUNT,
    ST_DATA,
    ST_WRITE,
    ST_CHECK
  } loader_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Host bytes needed to cover one buffered write, rounding up partial bytes.
  function automatic int bytes_per_wr(input int buffer_size, input int width);
    return (buffer_size * width + 7) / 8;
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects the data bytes of one instruction pair, little-endian, and presents
// the truncated pair word when its final byte arrives.
module imem_word_assembler
  import imem_loader_pkg::*;
#(
  parameter int DATA_W = 46,
  parameter int NBYTES = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  output logic              pair_done,
  output logic [DATA_W-1:0] data_out
);

  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  logic [IDX_W-1:0]    idx;
  logic [NBYTES*8-1:0] buf_q;
  logic [NBYTES*8-1:0] buf_next;

  always_comb begin
    buf_next = buf_q;
    buf_next[int'(idx)*8 +: 8] = byte_in;
  end

  assign pair_done = byte_valid && (idx == LAST_IDX);

  // Every byte of a pair is rewritten before it is used, so buf_q needs no
  // clearing between pairs; only the index must restart on a new frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx      <= '0;
      buf_q    <= '0;
      data_out <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (byte_valid) begin
      buf_q <= buf_next;
      if (idx == LAST_IDX) begin
        idx      <= '0;
        data_out <= buf_next[DATA_W-1:0];
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses framed host bytes (sync, address, pair count, data, checksum)
// and issues one instruction-buffer write per assembled instruction pair.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int I_ADR_WIDTH   = 10,
  parameter int I_WIDTH       = 23,
  parameter int I_BUFFER_SIZE = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [7:0]                         rx_data,
  input  logic                               rx_valid,
  output logic                               rx_ready,
  output logic [I_ADR_WIDTH-1:0]             imem_write_adr,
  output logic                               imem_write,
  output logic [I_BUFFER_SIZE*I_WIDTH-1:0]   imem_in,
  output logic                               loading,
  output logic                               load_done,
  output logic                               load_error,
  output loader_state_t                      dbg_state
);

  localparam int DATA_W       = I_BUFFER_SIZE * I_WIDTH;
  localparam int BYTES_PER_WR = bytes_per_wr(I_BUFFER_SIZE, I_WIDTH);

  // Handshake: a byte moves on any rising edge where rx_valid && rx_ready;
  // rx_valid may be held across stalls and the byte stays pending.
  loader_state_t          state, state_next;
  logic                   accept;
  logic                   sync_seen;
  logic                   pair_done;
  logic [I_ADR_WIDTH-1:0] cur_adr;
  logic [I_ADR_WIDTH-1:0] wr_adr_q;
  logic [8:0]             pairs_left;
  logic [7:0]             chk;

  assign accept         = rx_valid && rx_ready;
  assign sync_seen      = (state == ST_IDLE) && accept && (rx_data == SYNC_BYTE);
  assign rx_ready       = (state != ST_WRITE);
  assign imem_write     = (state == ST_WRITE);
  assign loading        = (state != ST_IDLE);
  assign imem_write_adr = wr_adr_q;
  assign dbg_state      = state;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (sync_seen) state_next = ST_ADR_LO;
      ST_ADR_LO: if (accept) state_next = ST_ADR_HI;
      ST_ADR_HI: if (accept) state_next = ST_COUNT;
      ST_COUNT:  if (accept) state_next = ST_DATA;
      ST_DATA:   if (pair_done) state_next = ST_WRITE;
      ST_WRITE:  state_next = (pairs_left == 9'd1) ? ST_CHECK : ST_DATA;
      ST_CHECK:  if (accept) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_adr    <= '0;
      wr_adr_q   <= '0;
      pairs_left <= '0;
      chk        <= '0;
      load_error <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sync_seen) begin
            load_error <= 1'b0;
            chk        <= '0;
          end
        end
        ST_ADR_LO: if (accept) cur_adr <= I_ADR_WIDTH'({8'h00, rx_data});
        // Only the low bits of the high address byte are meaningful.
        ST_ADR_HI: if (accept) cur_adr <= I_ADR_WIDTH'({rx_data, cur_adr[7:0]});
        ST_COUNT: begin
          if (accept) pairs_left <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
        end
        ST_DATA: begin
          if (accept)    chk      <= chk ^ rx_data;
          if (pair_done) wr_adr_q <= cur_adr;
        end
        ST_WRITE: begin
          cur_adr    <= cur_adr + I_ADR_WIDTH'(I_BUFFER_SIZE);
          pairs_left <= pairs_left - 9'd1;
        end
        ST_CHECK: begin
          if (accept) begin
            if (rx_data != chk) load_error <= 1'b1;
            load_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  imem_word_assembler #(
    .DATA_W (DATA_W),
    .NBYTES (BYTES_PER_WR)
  ) u_assembler (
    .clk        (clk),
    .reset      (reset),
    .clear      (sync_seen),
    .byte_valid ((state == ST_DATA) && accept),
    .byte_in    (rx_data),
    .pair_done  (pair_done),
    .data_out   (imem_in)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, address wrap, garbage/sync handling,
// checksum errors, full-rate stalls and mid-frame reset.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int AW = 10;
  localparam int DW = 46;

  logic          clk;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [AW-1:0] imem_write_adr;
  logic          imem_write;
  logic [DW-1:0] imem_in;
  logic          loading;
  logic          load_done;
  logic          load_error;
  loader_state_t dbg_state;

  imem_loader dut (
    .clk            (clk),
    .reset          (reset),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .imem_write_adr (imem_write_adr),
    .imem_write     (imem_write),
    .imem_in        (imem_in),
    .loading        (loading),
    .load_done      (load_done),
    .load_error     (load_error),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int vec_cnt   = 0;
  int miss_cnt  = 0;
  int stall_cnt = 0;
  int done_cnt  = 0;

  logic [AW-1:0] exp_adr_q[$];
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] obs_adr_q[$];
  logic [DW-1:0] obs_q[$];

  always @(negedge clk) begin
    if (imem_write) begin
      obs_adr_q.push_back(imem_write_adr);
      obs_q.push_back(imem_in);
    end
    if (load_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_n_writes"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      check({tag, "_adr"}, 64'(obs_adr_q.pop_front()), 64'(exp_adr_q.pop_front()));
      check({tag, "_data"}, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
    end
    obs_q.delete(); obs_adr_q.delete(); exp_q.delete(); exp_adr_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_ready"}, 64'(rx_ready), 64'd1);
    check({tag, "_imem_write"}, 64'(imem_write), 64'd0);
    check({tag, "_adr"}, 64'(imem_write_adr), 64'd0);
    check({tag, "_imem_in"}, 64'(imem_in), 64'd0);
    check({tag, "_loading"}, 64'(loading), 64'd0);
    check({tag, "_load_done"}, 64'(load_done), 64'd0);
    check({tag, "_load_error"}, 64'(load_error), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  // ---------------- drivers ----------------
  // Called at a falling edge; returns at the falling edge after the byte is taken.
  task automatic send_byte(input logic [7:0] b);
    logic ok;
    bit   sent;
    sent     = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 16 && !sent; i++) begin
      ok = rx_ready;
      @(negedge clk);
      if (ok) sent = 1'b1;
      else    stall_cnt++;
    end
    if (!sent) check("rx_accept_timeout", 64'd0, 64'd1);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("in_reset");
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [AW-1:0] adr, input logic [7:0] hi_junk,
                            input int count, input logic [7:0] seed,
                            input bit bad_chk, input bit gaps);
    logic [7:0]    chk;
    logic [7:0]    b;
    logic [47:0]   pair;
    logic [AW-1:0] a;
    chk = 8'h00;
    send_byte(SYNC_BYTE);
    check("loading_after_sync", 64'(loading), 64'd1);
    send_byte(adr[7:0]);
    send_byte({hi_junk[7:2], adr[9:8]});
    send_byte((count == 256) ? 8'h00 : 8'(count));
    for (int p = 0; p < count; p++) begin
      pair = '0;
      for (int k = 0; k < 6; k++) begin
        b = 8'(int'(seed) + p * 6 + k);
        pair[k*8 +: 8] = b;
        chk = chk ^ b;
        if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
        send_byte(b);
      end
      a = adr + AW'(2 * p);
      check("wr_strobe", 64'(imem_write), 64'd1);
      check("wr_rx_ready", 64'(rx_ready), 64'd0);
      check("wr_adr_live", 64'(imem_write_adr), 64'(a));
      check("wr_data_live", 64'(imem_in), 64'(pair[DW-1:0]));
      check("wr_loading", 64'(loading), 64'd1);
      exp_adr_q.push_back(a);
      exp_q.push_back(pair[DW-1:0]);
    end
    send_byte(bad_chk ? ~chk : chk);
    check("load_done_pulse", 64'(load_done), 64'd1);
    check("loading_end", 64'(loading), 64'd0);
    check("load_error_end", 64'(load_error), 64'(bad_chk));
    @(negedge clk);
    check("load_done_single", 64'(load_done), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    reset = 1'b0;
    @(negedge clk);

    // Single pair at 0x010, data 01..06, checksum 07.
    stall_cnt = 0;
    send_frame(10'h010, 8'h00, 1, 8'h01, 1'b0, 1'b0);
    check("A_stalls", 64'(stall_cnt), 64'd1);
    check("A_known_data", 64'(imem_in), 64'h0000_0605_0403_0201);
    check_writes("A");
    check("A_done_cnt", 64'(done_cnt), 64'd1);

    // Garbage before sync, then three pairs wrapping past the top of memory;
    // seed A5 also places a sync value inside the data.
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    check("garbage_not_loading", 64'(loading), 64'd0);
    stall_cnt = 0;
    send_frame(10'h3FE, 8'hFC, 3, 8'hA5, 1'b0, 1'b0);
    check("B_stalls", 64'(stall_cnt), 64'd3);
    check_writes("B");
    check("B_done_cnt", 64'(done_cnt), 64'd2);

    // Bad checksum with random gaps; junk in the high address byte.
    send_frame(10'h100, 8'hFC, 2, 8'h40, 1'b1, 1'b1);
    check_writes("C");
    idle(5);
    check("C_error_sticky", 64'(load_error), 64'd1);
    send_byte(SYNC_BYTE);
    check("C_sync_clears_error", 64'(load_error), 64'd0);
    check("C_sync_loading", 64'(loading), 64'd1);

    // Abort that frame with reset after three data bytes.
    send_byte(8'h20);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    check("R_no_write_before_reset", 64'(imem_write), 64'd0);
    do_reset();
    check_reset_values("after_reset");
    check("R_no_writes", 64'(obs_q.size()), 64'd0);

    // COUNT=0 means 256 pairs; address runs 0x000..0x1FE.
    stall_cnt = 0;
    send_frame(10'h000, 8'h00, 256, 8'h00, 1'b0, 1'b0);
    check("D_stalls", 64'(stall_cnt), 64'd256);
    check("D_last_adr", 64'(imem_write_adr), 64'h1FE);
    check_writes("D");
    check("D_done_cnt", 64'(done_cnt), 64'd4);

    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
